manchester_pulse_classifier: RTL

- Sequencer for the receive-side pulse-width windows of the 1553 decoder. Runs a run-length counter on the sampled bus level and, at each level transition, checks the completed run against three inclusive windows: half-bit, full-bit and sync (1.5-bit).
- Emits one classified symbol per transition to the downstream Manchester/sync decoder.
- Sits between the input synchronizer/sampler and the word decoder.

---
 rtl/manchester_pulse_classifier_if.sv | 29 ++
 rtl/manchester_pulse_classifier.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/manchester_pulse_classifier_if.sv
// Bundle between the bus sampler, the pulse classifier and the word decoder.
// master drives the sample/control side; slave is the classifier itself.
interface manchester_pulse_classifier_if #(
    parameter int COUNTER_SIZE = 5
);
    logic                    i_enable;
    logic                    i_sample_en;
    logic                    i_rx_data;
    logic                    i_err_clr;
    logic                    o_sym_valid;
    logic [1:0]              o_sym_code;
    logic                    o_sym_level;
    logic [COUNTER_SIZE-1:0] o_sym_len;
    logic                    o_timeout;
    logic                    o_busy;
    logic [15:0]             o_err_count;

    modport master (
        output i_enable, i_sample_en, i_rx_data, i_err_clr,
        input  o_sym_valid, o_sym_code, o_sym_level, o_sym_len,
               o_timeout, o_busy, o_err_count
    );

    modport slave (
        input  i_enable, i_sample_en, i_rx_data, i_err_clr,
        output o_sym_valid, o_sym_code, o_sym_level, o_sym_len,
               o_timeout, o_busy, o_err_count
    );
endinterface

// File: rtl/manchester_pulse_classifier.sv
// Run-length pulse classifier for the 1553 receive path: one short/long/sync/invalid symbol per level transition.
// Optional error statistics counter enabled by defining MANCHESTER_PULSE_CLASSIFIER_STATS_EN.
module manchester_pulse_classifier #(
    parameter int COUNTER_SIZE = 5,
    parameter int SHORT_MIN    = 6,
    parameter int SHORT_MAX    = 10,
    parameter int LONG_MIN     = 14,
    parameter int LONG_MAX     = 18,
    parameter int SYNC_MIN     = 22,
    parameter int SYNC_MAX     = 26
) (
    input logic                         i_clk,
    input logic                         i_rst,
    manchester_pulse_classifier_if.slave bus
);

    localparam int MAX_COUNT = (2 ** COUNTER_SIZE) - 1;

    if (SHORT_MIN >= SHORT_MAX || LONG_MIN >= LONG_MAX || SYNC_MIN >= SYNC_MAX) begin : g_bad_order
        $fatal(1, "manchester_pulse_classifier: window lower bound must be below upper bound");
    end
    if (SHORT_MAX >= LONG_MIN || LONG_MAX >= SYNC_MIN) begin : g_bad_overlap
        $fatal(1, "manchester_pulse_classifier: windows overlap or are out of order");
    end
    if (SYNC_MAX >= MAX_COUNT) begin : g_bad_range
        $fatal(1, "manchester_pulse_classifier: sync window does not fit the run counter");
    end
    if (SHORT_MIN == 0) begin : g_bad_zero
        $fatal(1, "manchester_pulse_classifier: SHORT_MIN must be non-zero");
    end

    localparam logic [COUNTER_SIZE-1:0] MAX_C       = COUNTER_SIZE'(MAX_COUNT);
    localparam logic [COUNTER_SIZE-1:0] ONE_C       = COUNTER_SIZE'(1);
    localparam logic [COUNTER_SIZE-1:0] SHORT_MIN_C = COUNTER_SIZE'(SHORT_MIN);
    localparam logic [COUNTER_SIZE-1:0] SHORT_MAX_C = COUNTER_SIZE'(SHORT_MAX);
    localparam logic [COUNTER_SIZE-1:0] LONG_MIN_C  = COUNTER_SIZE'(LONG_MIN);
    localparam logic [COUNTER_SIZE-1:0] LONG_MAX_C  = COUNTER_SIZE'(LONG_MAX);
    localparam logic [COUNTER_SIZE-1:0] SYNC_MIN_C  = COUNTER_SIZE'(SYNC_MIN);
    localparam logic [COUNTER_SIZE-1:0] SYNC_MAX_C  = COUNTER_SIZE'(SYNC_MAX);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_ARM       = 2'b01,
        ST_WAIT_EDGE = 2'b10,
        ST_MEASURE   = 2'b11
    } state_t;

    function automatic logic [1:0] classify(input logic [COUNTER_SIZE-1:0] len);
        if (len >= SHORT_MIN_C && len <= SHORT_MAX_C) begin
            classify = 2'b00;
        end else if (len >= LONG_MIN_C && len <= LONG_MAX_C) begin
            classify = 2'b01;
        end else if (len >= SYNC_MIN_C && len <= SYNC_MAX_C) begin
            classify = 2'b10;
        end else begin
            classify = 2'b11;
        end
    endfunction

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic                    level_r;
    logic [COUNTER_SIZE-1:0] count_r;
    logic                    edge_s;
    logic                    sym_fire_s;
    logic                    timeout_fire_s;
    logic [1:0]              code_s;

    logic                    sym_valid_r;
    logic [1:0]              sym_code_r;
    logic                    sym_level_r;
    logic [COUNTER_SIZE-1:0] sym_len_r;
    logic                    timeout_r;

    assign edge_s = (bus.i_rx_data != level_r);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a dropped enable overrides everything
    always_comb begin
        state_nxt_s = state_r;
        if (!bus.i_enable) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_nxt_s = ST_ARM;
                ST_ARM: begin
                    if (bus.i_sample_en) begin
                        state_nxt_s = ST_WAIT_EDGE;
                    end else begin
                        state_nxt_s = ST_ARM;
                    end
                end
                ST_WAIT_EDGE: begin
                    if (bus.i_sample_en && edge_s) begin
                        state_nxt_s = ST_MEASURE;
                    end else begin
                        state_nxt_s = ST_WAIT_EDGE;
                    end
                end
                ST_MEASURE: begin
                    if (timeout_fire_s) begin
                        state_nxt_s = ST_WAIT_EDGE;
                    end else begin
                        state_nxt_s = ST_MEASURE;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Symbol/timeout decisions for the current strobe
    always_comb begin
        sym_fire_s     = 1'b0;
        timeout_fire_s = 1'b0;
        code_s         = classify(count_r);
        if (bus.i_enable && bus.i_sample_en && state_r == ST_MEASURE) begin
            if (edge_s) begin
                sym_fire_s = 1'b1;
            end else if (count_r == MAX_C) begin
                timeout_fire_s = 1'b1;
            end else begin
                sym_fire_s     = 1'b0;
                timeout_fire_s = 1'b0;
            end
        end else begin
            sym_fire_s     = 1'b0;
            timeout_fire_s = 1'b0;
        end
    end

    // Stored level and run-length counter, advanced only on sample strobes
    always_ff @(posedge i_clk) begin
        if (i_rst || !bus.i_enable) begin
            level_r <= 1'b0;
            count_r <= '0;
        end else if (bus.i_sample_en) begin
            case (state_r)
                ST_ARM: level_r <= bus.i_rx_data;
                ST_WAIT_EDGE, ST_MEASURE: begin
                    if (edge_s) begin
                        level_r <= bus.i_rx_data;
                        count_r <= ONE_C;
                    end else if (state_r == ST_MEASURE && count_r != MAX_C) begin
                        count_r <= count_r + ONE_C;
                    end else begin
                        count_r <= '0;
                    end
                end
                default: count_r <= '0;
            endcase
        end
    end

    // Registered symbol outputs; the payload holds until the next symbol
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sym_valid_r <= 1'b0;
            sym_code_r  <= 2'b00;
            sym_level_r <= 1'b0;
            sym_len_r   <= '0;
            timeout_r   <= 1'b0;
        end else begin
            sym_valid_r <= sym_fire_s;
            timeout_r   <= timeout_fire_s;
            if (sym_fire_s) begin
                sym_code_r  <= code_s;
                sym_level_r <= level_r;
                sym_len_r   <= count_r;
            end
        end
    end

    assign bus.o_sym_valid = sym_valid_r;
    assign bus.o_sym_code  = sym_code_r;
    assign bus.o_sym_level = sym_level_r;
    assign bus.o_sym_len   = sym_len_r;
    assign bus.o_timeout   = timeout_r;
    assign bus.o_busy      = (state_r == ST_MEASURE);

`ifdef MANCHESTER_PULSE_CLASSIFIER_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] err_count_r;
    logic        err_inc_s;

    assign err_inc_s = (sym_fire_s && code_s == 2'b11) || timeout_fire_s;

    // Saturating error counter; clear takes priority over a same-cycle error
    always_ff @(posedge i_clk) begin
        if (i_rst || bus.i_err_clr) begin
            err_count_r <= 16'h0000;
        end else if (err_inc_s) begin
            err_count_r <= sat_inc(err_count_r);
        end
    end

    assign bus.o_err_count = err_count_r;
`else
    assign bus.o_err_count = 16'h0000;
`endif

endmodule
